ddcb_delay_ctrl: RTL and testbench

Calibration and configuration controller for the DDCB cascaded delay line. It sweeps the line's per-stage select vector under a thermometer code until a sampled phase-detector signal crosses over, then holds lock with hysteresis tracking. It also accepts manual code requests over a valid/ready handshake. Every code change is one stage at a time, followed by a settle interval, so the delayed signal never sees a multi-bit select glitch.

---
 rtl/ddcb_pkg.sv | 39 +++
 rtl/ddcb_phase_window.sv | 43 ++++
 rtl/ddcb_delay_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_ddcb_delay_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddcb_pkg.sv
// ddcb_pkg: shared types and helpers for the DDCB delay-line controller.
//   ddcb_ctrl_state_e : controller state encoding
//   ddcb_trk_phase_e  : window phase while tracking in LOCKED
//   code_width()      : width needed to hold codes 0..stages
//   thermo()          : thermometer select vector for a code, (1<<code)-1
package ddcb_pkg;

  localparam int unsigned MAX_STAGES = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_LOCKED,
    ST_MANUAL,
    ST_ERROR
  } ddcb_ctrl_state_e;

  typedef enum logic [1:0] {
    TRK_SETTLE,
    TRK_SAMPLE,
    TRK_DECIDE
  } ddcb_trk_phase_e;

  function automatic int unsigned code_width(input int unsigned stages);
    return $clog2(stages + 1);
  endfunction

  function automatic logic [MAX_STAGES-1:0] thermo(input int unsigned code);
    logic [MAX_STAGES-1:0] v;
    v = '0;
    for (int unsigned i = 0; i < MAX_STAGES; i++) begin
      if (i < code) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/ddcb_phase_window.sv
// ddcb_phase_window: counts phase_early samples over one decision window.
//   clk, rst     : clock, synchronous active-high reset
//   clear        : zero the count (asserted just before a window starts)
//   en           : sample phase_early this cycle
//   phase_early  : detector output, 1 = more delay needed
//   early        : majority of samples were early (2*cnt > AVG_SAMPLES)
//   strong_early : every sample early
//   strong_late  : no sample early
module ddcb_phase_window #(
  parameter  int unsigned AVG_SAMPLES = 8,
  localparam int unsigned CNT_W       = $clog2(AVG_SAMPLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  input  logic phase_early,
  output logic early,
  output logic strong_early,
  output logic strong_late
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && phase_early) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign early        = {cnt_q, 1'b0} > (CNT_W + 1)'(AVG_SAMPLES);
  assign strong_early = cnt_q == CNT_W'(AVG_SAMPLES);
  assign strong_late  = cnt_q == '0;

endmodule

// File: rtl/ddcb_delay_ctrl.sv
// ddcb_delay_ctrl: calibration / tracking / manual controller for the DDCB
// cascaded delay line. The code only ever moves one stage at a time and each
// step is followed by a settle interval before the phase detector is trusted.
//   clk, rst       : clock, synchronous active-high reset
//   cal_start      : pulse, restart calibration from code 0 (rest states only)
//   phase_early    : synchronized detector, 1 = more delay needed
//   manual_valid/manual_code/manual_ready : manual code request handshake
//   select         : registered thermometer select, (1<<code)-1
//   code           : current code 0..Nmbr_cascades
//   busy/locked/cal_err : status decoded from the controller state
module ddcb_delay_ctrl
  import ddcb_pkg::*;
#(
  parameter  int unsigned Nmbr_cascades = 6,
  parameter  int unsigned SETTLE_CYCLES = 4,
  parameter  int unsigned AVG_SAMPLES   = 8,
  localparam int unsigned CODE_W        = code_width(Nmbr_cascades)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cal_start,
  input  logic                     phase_early,
  input  logic                     manual_valid,
  input  logic [CODE_W-1:0]        manual_code,
  output logic                     manual_ready,
  output logic [Nmbr_cascades-1:0] select,
  output logic [CODE_W-1:0]        code,
  output logic                     busy,
  output logic                     locked,
  output logic                     cal_err
);

  localparam int unsigned TMR_MAX = (SETTLE_CYCLES > AVG_SAMPLES) ? SETTLE_CYCLES : AVG_SAMPLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [CODE_W-1:0] CODE_MAX    = CODE_W'(Nmbr_cascades);
  localparam logic [TMR_W-1:0]  SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0]  SAMPLE_LAST = TMR_W'(AVG_SAMPLES - 1);
  localparam logic [TMR_W-1:0]  STEP_WAIT   = TMR_W'(SETTLE_CYCLES);

  ddcb_ctrl_state_e          state_q, state_d;
  ddcb_trk_phase_e           trk_q, trk_d;
  logic [CODE_W-1:0]         code_q, code_d;
  logic [CODE_W-1:0]         target_q, target_d;
  logic [TMR_W-1:0]          tmr_q, tmr_d;
  logic [Nmbr_cascades-1:0]  select_q, select_d;

  logic              rest;
  logic [CODE_W-1:0] manual_sat;
  logic              win_clear, win_en;
  logic              win_early, win_strong_early, win_strong_late;

  ddcb_phase_window #(
    .AVG_SAMPLES(AVG_SAMPLES)
  ) u_window (
    .clk         (clk),
    .rst         (rst),
    .clear       (win_clear),
    .en          (win_en),
    .phase_early (phase_early),
    .early       (win_early),
    .strong_early(win_strong_early),
    .strong_late (win_strong_late)
  );

  assign rest         = (state_q == ST_IDLE) || (state_q == ST_LOCKED) || (state_q == ST_ERROR);
  assign manual_ready = rest && !cal_start;
  assign manual_sat   = (manual_code > CODE_MAX) ? CODE_MAX : manual_code;

  always_comb begin
    state_d   = state_q;
    trk_d     = trk_q;
    code_d    = code_q;
    target_d  = target_q;
    tmr_d     = tmr_q;
    win_clear = 1'b0;
    win_en    = 1'b0;

    // Rest-state requests pre-empt tracking; cal_start beats a manual request.
    if (rest && cal_start) begin
      code_d  = '0;
      tmr_d   = '0;
      state_d = ST_SETTLE;
    end else if (rest && manual_valid) begin
      target_d = manual_sat;
      tmr_d    = '0;
      state_d  = ST_MANUAL;
    end else begin
      case (state_q)
        ST_SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            tmr_d     = '0;
            win_clear = 1'b1;
            state_d   = ST_SAMPLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_SAMPLE: begin
          win_en = 1'b1;
          if (tmr_q == SAMPLE_LAST) begin
            tmr_d   = '0;
            state_d = ST_DECIDE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_DECIDE: begin
          if (win_early) begin
            if (code_q == CODE_MAX) begin
              state_d = ST_ERROR;
            end else begin
              code_d  = code_q + CODE_W'(1);
              state_d = ST_SETTLE;
            end
          end else if (code_q == '0) begin
            state_d = ST_ERROR;
          end else begin
            trk_d   = TRK_SETTLE;
            state_d = ST_LOCKED;
          end
        end
        // Tracking reuses the settle/sample/decide window as a sub-phase so
        // that locked stays high and busy stays low for the whole time.
        ST_LOCKED: begin
          case (trk_q)
            TRK_SETTLE: begin
              if (tmr_q == SETTLE_LAST) begin
                tmr_d     = '0;
                win_clear = 1'b1;
                trk_d     = TRK_SAMPLE;
              end else begin
                tmr_d = tmr_q + TMR_W'(1);
              end
            end
            TRK_SAMPLE: begin
              win_en = 1'b1;
              if (tmr_q == SAMPLE_LAST) begin
                tmr_d = '0;
                trk_d = TRK_DECIDE;
              end else begin
                tmr_d = tmr_q + TMR_W'(1);
              end
            end
            TRK_DECIDE: begin
              trk_d = TRK_SETTLE;
              if (win_strong_early) begin
                if (code_q == CODE_MAX) state_d = ST_ERROR;
                else                    code_d  = code_q + CODE_W'(1);
              end else if (win_strong_late) begin
                if (code_q == '0) state_d = ST_ERROR;
                else              code_d  = code_q - CODE_W'(1);
              end
            end
            default: trk_d = TRK_SETTLE;
          endcase
        end
        // Wait SETTLE_CYCLES, then step; leaves on the same cycle as the
        // final step so the step spacing is SETTLE_CYCLES+1.
        ST_MANUAL: begin
          if (code_q == target_q) begin
            state_d = ST_IDLE;
          end else if (tmr_q == STEP_WAIT) begin
            tmr_d = '0;
            if (target_q > code_q) code_d = code_q + CODE_W'(1);
            else                   code_d = code_q - CODE_W'(1);
            if (code_d == target_q) state_d = ST_IDLE;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        ST_IDLE, ST_ERROR: ;
        default: state_d = ST_IDLE;
      endcase
    end

    select_d = Nmbr_cascades'(thermo(32'(code_d)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      trk_q    <= TRK_SETTLE;
      code_q   <= '0;
      target_q <= '0;
      tmr_q    <= '0;
      select_q <= '0;
    end else begin
      state_q  <= state_d;
      trk_q    <= trk_d;
      code_q   <= code_d;
      target_q <= target_d;
      tmr_q    <= tmr_d;
      select_q <= select_d;
    end
  end

  assign select  = select_q;
  assign code    = code_q;
  assign busy    = state_q inside {ST_SETTLE, ST_SAMPLE, ST_DECIDE, ST_MANUAL};
  assign locked  = state_q == ST_LOCKED;
  assign cal_err = state_q == ST_ERROR;

endmodule

// File: tb/tb_ddcb_delay_ctrl.sv
// tb_ddcb_delay_ctrl: scenario tasks for the DDCB delay controller. Expected
// code/select changes are queued when stimulus is applied and consumed by a
// monitor whenever the DUT code changes.
module tb_ddcb_delay_ctrl;

  localparam int N  = 6;
  localparam int CW = 3;
  localparam int T  = 4 + 8 + 1;

  logic          clk;
  logic          rst;
  logic          cal_start;
  logic          phase_early;
  logic          manual_valid;
  logic [CW-1:0] manual_code;
  logic          manual_ready;
  logic [N-1:0]  select;
  logic [CW-1:0] code;
  logic          busy;
  logic          locked;
  logic          cal_err;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;
  int pe_mode = 0;   // 0: low, 1: high, 2: high while code<3, 3: alternate
  bit mon_en = 1'b0;

  typedef struct {
    int           at;
    logic [CW-1:0] c;
    logic [N-1:0]  s;
    bit           one_bit;
  } exp_t;

  exp_t exp_q[$];
  logic [CW-1:0] prev_code;
  logic [N-1:0]  prev_sel;

  ddcb_delay_ctrl #(
    .Nmbr_cascades(6),
    .SETTLE_CYCLES(4),
    .AVG_SAMPLES  (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cal_start   (cal_start),
    .phase_early (phase_early),
    .manual_valid(manual_valid),
    .manual_code (manual_code),
    .manual_ready(manual_ready),
    .select      (select),
    .code        (code),
    .busy        (busy),
    .locked      (locked),
    .cal_err     (cal_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    case (pe_mode)
      0:       phase_early = 1'b0;
      1:       phase_early = 1'b1;
      2:       phase_early = (code < 3);
      default: phase_early = cyc[0];
    endcase
  end

  function automatic logic [N-1:0] therm_model(input int c);
    return N'((1 << c) - 1);
  endfunction

  task automatic push_exp(input int at, input int c, input bit one_bit);
    exp_t e;
    e.at      = at;
    e.c       = CW'(c);
    e.s       = therm_model(c);
    e.one_bit = one_bit;
    exp_q.push_back(e);
  endtask

  // Scoreboard consumer: every code change must match the next queued change.
  always @(negedge clk) begin
    if (mon_en && code !== prev_code) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change: cyc %0d code %0d select %b, none expected", cyc, code, select);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (code !== e.c || select !== e.s || cyc !== e.at) begin
          errors++;
          $display("FAIL code_change: got code %0d select %b at cyc %0d, want code %0d select %b at cyc %0d",
                   code, select, cyc, e.c, e.s, e.at);
        end else if (e.one_bit && $countones(select ^ prev_sel) != 1) begin
          errors++;
          $display("FAIL single_bit: select %b -> %b at cyc %0d", prev_sel, select, cyc);
        end
      end
    end
    prev_code = code;
    prev_sel  = select;
  end

  task automatic test_reset;
    rst = 1'b1; cal_start = 1'b0; manual_valid = 1'b0; manual_code = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (select !== '0 || code !== '0) begin
      errors++; $display("FAIL reset_code: got code %0d select %b, want 0 / 000000", code, select);
    end
    checks++;
    if (busy !== 1'b0 || locked !== 1'b0 || cal_err !== 1'b0) begin
      errors++; $display("FAIL reset_status: got busy %b locked %b cal_err %b, want 0 0 0", busy, locked, cal_err);
    end
    checks++;
    if (manual_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", manual_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_calibration;
    int t0;
    int n;
    t0 = cyc;
    pe_mode = 2;
    cal_start = 1'b1;
    for (int k = 1; k <= 3; k++) push_exp(t0 + 1 + k * T, k, 1'b1);
    @(negedge clk);
    cal_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || code !== '0) begin
      errors++; $display("FAIL cal_start: got busy %b code %0d, want 1 0", busy, code);
    end
    n = 0;
    while (locked !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (locked !== 1'b1 || cyc !== t0 + 53) begin
      errors++; $display("FAIL cal_lock_time: got locked %b at cyc %0d, want 1 at %0d", locked, cyc - t0, 53);
    end
    checks++;
    if (code !== 3'd3 || select !== 6'b000111 || busy !== 1'b0 || cal_err !== 1'b0) begin
      errors++; $display("FAIL cal_lock_code: got code %0d select %b busy %b err %b, want 3 000111 0 0",
                         code, select, busy, cal_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL cal_pending: got %0d queued, want 0", exp_q.size());
    end
  endtask

  task automatic test_tracking;
    int t1;
    bit bad;
    t1 = cyc;
    bad = 1'b0;
    pe_mode = 1;
    push_exp(t1 + 13, 4, 1'b1);
    repeat (13) begin
      @(negedge clk);
      if (locked !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || code !== 3'd4) begin
      errors++; $display("FAIL track_up: got code %0d lost_lock %b, want 4 0", code, bad);
    end
    pe_mode = 3;
    repeat (3 * T) begin
      @(negedge clk);
      if (locked !== 1'b1 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad || code !== 3'd4) begin
      errors++; $display("FAIL track_hold: got code %0d lost_lock %b, want 4 0", code, bad);
    end
  endtask

  task automatic test_overflow;
    int t0;
    int n;
    t0 = cyc;
    pe_mode = 1;
    cal_start = 1'b1;
    push_exp(t0 + 1, 0, 1'b0);
    for (int k = 1; k <= N; k++) push_exp(t0 + 1 + k * T, k, 1'b1);
    @(negedge clk);
    cal_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || locked !== 1'b0) begin
      errors++; $display("FAIL ovf_start: got busy %b locked %b, want 1 0", busy, locked);
    end
    n = 0;
    while (cal_err !== 1'b1 && n < 150) begin @(negedge clk); n++; end
    checks++;
    if (cal_err !== 1'b1 || cyc !== t0 + 92) begin
      errors++; $display("FAIL ovf_time: got cal_err %b at cyc %0d, want 1 at 92", cal_err, cyc - t0);
    end
    checks++;
    if (code !== 3'd6 || select !== 6'b111111 || locked !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ovf_state: got code %0d select %b locked %b busy %b, want 6 111111 0 0",
                         code, select, locked, busy);
    end
  endtask

  task automatic test_underflow;
    int t0;
    int n;
    t0 = cyc;
    pe_mode = 0;
    cal_start = 1'b1;
    push_exp(t0 + 1, 0, 1'b0);
    @(negedge clk);
    cal_start = 1'b0;
    checks++;
    if (busy !== 1'b1 || cal_err !== 1'b0) begin
      errors++; $display("FAIL udf_start: got busy %b cal_err %b, want 1 0", busy, cal_err);
    end
    n = 0;
    while (cal_err !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cal_err !== 1'b1 || cyc !== t0 + 14 || code !== '0 || select !== '0) begin
      errors++; $display("FAIL udf_err: got cal_err %b at cyc %0d code %0d, want 1 at 14 code 0",
                         cal_err, cyc - t0, code);
    end
  endtask

  task automatic test_reset_midrun;
    int t0;
    t0 = cyc;
    pe_mode = 1;
    cal_start = 1'b1;
    for (int k = 1; k <= 4; k++) push_exp(t0 + 1 + k * T, k, 1'b1);
    @(negedge clk);
    cal_start = 1'b0;
    while (cyc < t0 + 55) @(negedge clk);
    checks++;
    if (code !== 3'd4 || busy !== 1'b1) begin
      errors++; $display("FAIL midrun_pre: got code %0d busy %b, want 4 1", code, busy);
    end
    rst = 1'b1;
    push_exp(t0 + 56, 0, 1'b0);
    @(negedge clk);
    checks++;
    if (select !== '0 || code !== '0 || busy !== 1'b0 || locked !== 1'b0 || cal_err !== 1'b0) begin
      errors++; $display("FAIL midrun_reset: got select %b code %0d busy %b locked %b err %b, want all 0",
                         select, code, busy, locked, cal_err);
    end
    rst = 1'b0;
    pe_mode = 0;
    @(negedge clk);
  endtask

  task automatic test_manual;
    int t0;
    bit bad;
    t0 = cyc;
    bad = 1'b0;
    manual_valid = 1'b1;
    manual_code = 3'd5;
    #1;
    checks++;
    if (manual_ready !== 1'b1) begin
      errors++; $display("FAIL man_ready: got %b want 1", manual_ready);
    end
    for (int k = 1; k <= 5; k++) push_exp(t0 + 1 + 5 * k, k, 1'b1);
    @(negedge clk);
    manual_valid = 1'b0;
    for (int n = 1; n <= 25; n++) begin
      if (busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad || busy !== 1'b0 || code !== 3'd5 || locked !== 1'b0 || cal_err !== 1'b0) begin
      errors++; $display("FAIL man_done: got busy_gap %b busy %b code %0d at cyc %0d, want 0 0 5 at 26",
                         bad, busy, code, cyc - t0);
    end
  endtask

  task automatic test_manual_saturate;
    int t0;
    bit bad;
    t0 = cyc;
    bad = 1'b0;
    manual_valid = 1'b1;
    manual_code = 3'd7;
    push_exp(t0 + 6, 6, 1'b1);
    @(negedge clk);
    manual_valid = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      if (busy !== 1'b1) bad = 1'b1;
      @(negedge clk);
    end
    checks++;
    if (bad || busy !== 1'b0 || code !== 3'd6 || select !== 6'b111111) begin
      errors++; $display("FAIL man_sat: got busy_gap %b busy %b code %0d select %b, want 0 0 6 111111",
                         bad, busy, code, select);
    end
  endtask

  task automatic test_manual_same;
    manual_valid = 1'b1;
    manual_code = 3'd6;
    @(negedge clk);
    manual_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL man_same_busy: got %b want 1", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || code !== 3'd6) begin
      errors++; $display("FAIL man_same_idle: got busy %b code %0d, want 0 6", busy, code);
    end
  endtask

  task automatic test_collision;
    int t0;
    int n;
    t0 = cyc;
    pe_mode = 0;
    cal_start = 1'b1;
    manual_valid = 1'b1;
    manual_code = 3'd2;
    #1;
    checks++;
    if (manual_ready !== 1'b0) begin
      errors++; $display("FAIL coll_ready: got %b want 0", manual_ready);
    end
    push_exp(t0 + 1, 0, 1'b0);
    @(negedge clk);
    cal_start = 1'b0;
    manual_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || code !== '0) begin
      errors++; $display("FAIL coll_start: got busy %b code %0d, want 1 0", busy, code);
    end
    n = 0;
    while (cal_err !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (cal_err !== 1'b1 || cyc !== t0 + 14 || code !== '0) begin
      errors++; $display("FAIL coll_cal: got cal_err %b at cyc %0d code %0d, want 1 at 14 code 0",
                         cal_err, cyc - t0, code);
    end
  endtask

  initial begin
    test_reset();
    test_calibration();
    test_tracking();
    test_overflow();
    test_underflow();
    test_reset_midrun();
    test_manual();
    test_manual_saturate();
    test_manual_same();
    test_collision();
    repeat (2) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL leftover: got %0d queued changes, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
